// File: rtl/cursor_cmd_gen.sv
// Keystroke-to-cursor command generator: turns accepted key codes into cursor counter
// command pulses and text-buffer writes, using the counter output as position feedback.
module cursor_cmd_gen #(
  parameter int unsigned LINE_W    = 16,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [5:0] Q_IN,
  output logic       increase,
  output logic       decrease,
  output logic       parallel,
  output logic       clear,
  output logic [5:0] load,
  output logic       wr_en,
  output logic [5:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam logic [7:0] KeyHome  = 8'h01;
  localparam logic [7:0] KeyLeft  = 8'h02;
  localparam logic [7:0] KeyEnd   = 8'h05;
  localparam logic [7:0] KeyRight = 8'h06;
  localparam logic [7:0] KeyBs    = 8'h08;
  localparam logic [7:0] KeyFf    = 8'h0C;
  localparam logic [7:0] KeyCr    = 8'h0D;

  localparam logic [5:0] LineMask = 6'(LINE_W - 1);
  localparam logic [5:0] LineStep = 6'(LINE_W);
  localparam logic [5:0] PosMax   = 6'd63;

  typedef enum logic [2:0] {
    StIdle, StWrite, StCtrl, StBsDec, StBsWr, StSweep, StSweepEnd
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] code_q, code_d;
  logic [5:0] sweep_q, sweep_d;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= StIdle;
      code_q  <= '0;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StIdle: begin
        if (key_valid) begin
          code_d = key_code;
          if (key_code >= 8'h20 && key_code <= 8'h7E) begin
            state_d = StWrite;
          end else if (key_code == KeyBs && Q_IN != 6'd0) begin
            state_d = StBsDec;
          end else if (key_code == KeyFf) begin
            state_d = StSweep;
            sweep_d = '0;
          end else begin
            state_d = StCtrl;
          end
        end
      end
      StBsDec: state_d = StBsWr;
      StSweep: begin
        sweep_d = sweep_q + 6'd1;
        if (sweep_q == PosMax) state_d = StSweepEnd;
      end
      StWrite, StCtrl, StBsWr, StSweepEnd: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode the registered state; Q_IN is sampled in the issuing cycle.
  always_comb begin
    key_ready = (state_q == StIdle);
    increase  = 1'b0;
    decrease  = 1'b0;
    parallel  = 1'b0;
    clear     = 1'b0;
    load      = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    unique case (state_q)
      StWrite: begin
        wr_en    = 1'b1;
        wr_addr  = Q_IN;
        wr_data  = code_q;
        increase = (Q_IN != PosMax);
      end
      StCtrl: begin
        case (code_q)
          KeyLeft:  decrease = (Q_IN != 6'd0);
          KeyRight: increase = (Q_IN != PosMax);
          KeyHome:  parallel = 1'b1;
          KeyEnd: begin
            parallel = 1'b1;
            load     = PosMax;
          end
          KeyCr: begin
            parallel = 1'b1;
            load     = (Q_IN & ~LineMask) + LineStep;
          end
          default: ;
        endcase
      end
      StBsDec: decrease = 1'b1;
      StBsWr: begin
        wr_en   = 1'b1;
        wr_addr = Q_IN;
        wr_data = FILL_CHAR;
      end
      StSweep: begin
        wr_en   = 1'b1;
        wr_addr = sweep_q;
        wr_data = FILL_CHAR;
      end
      StSweepEnd: clear = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cursor_cmd_gen.sv
// Bench for cursor_cmd_gen: a simple cursor counter closes the Q_IN loop, and a per-key
// reference model predicts every output cycle of each transaction.
module tb_cursor_cmd_gen;

  localparam int unsigned LineW = 16;
  localparam logic [7:0]  Fill  = 8'h20;

  logic       CLK = 1'b0;
  logic       CLR_N;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [5:0] q_in = '0;
  logic       increase, decrease, parallel, clear;
  logic [5:0] load;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [7:0] wr_data;

  int tests = 0;
  int fails = 0;

  logic       set_req = 1'b0;
  logic [5:0] set_val = '0;
  logic [5:0] model_pos = '0;

  cursor_cmd_gen #(.LINE_W(LineW), .FILL_CHAR(Fill)) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .Q_IN      (q_in),
    .increase  (increase),
    .decrease  (decrease),
    .parallel  (parallel),
    .clear     (clear),
    .load      (load),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  always #5 CLK = ~CLK;

  // Cursor counter in the environment, driven by the DUT pulses.
  always @(posedge CLK) begin
    if (set_req)       q_in <= set_val;
    else if (increase) q_in <= q_in + 6'd1;
    else if (decrease) q_in <= q_in - 6'd1;
    else if (parallel) q_in <= load;
    else if (clear)    q_in <= '0;
  end

  function automatic logic [25:0] pk(input logic kr, input logic inc, input logic dec,
                                     input logic par, input logic clr, input logic [5:0] ld,
                                     input logic we, input logic [5:0] wa,
                                     input logic [7:0] wd);
    return {kr, inc, dec, par, clr, ld, we, wa, wd};
  endfunction

  function automatic logic [25:0] obs();
    return {key_ready, increase, decrease, parallel, clear, load, wr_en, wr_addr, wr_data};
  endfunction

  task automatic chk(input string tag, input logic [25:0] o, input logic [25:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic set_pos(input logic [5:0] v);
    set_req = 1'b1;
    set_val = v;
    @(posedge CLK); #1;
    set_req   = 1'b0;
    model_pos = v;
  endtask

  // Predict the full transaction for key k from the cursor position, then run and compare.
  task automatic run_key(input logic [7:0] k);
    logic [25:0] exp_q[$];
    logic [5:0]  p, np;
    int          nxt;
    p  = model_pos;
    np = p;
    chk("cursor_pos", {20'd0, q_in}, {20'd0, p});
    chk("ready_before", {25'd0, key_ready}, 26'd1);
    if (k >= 8'h20 && k <= 8'h7E) begin
      exp_q.push_back(pk(0, p != 63, 0, 0, 0, 0, 1, p, k));
      np = (p == 63) ? p : p + 6'd1;
    end else begin
      case (k)
        8'h08: begin
          if (p == 0) exp_q.push_back(26'd0);
          else begin
            np = p - 6'd1;
            exp_q.push_back(pk(0, 0, 1, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 1, np, Fill));
          end
        end
        8'h02: begin
          exp_q.push_back(pk(0, 0, p != 0, 0, 0, 0, 0, 0, 0));
          if (p != 0) np = p - 6'd1;
        end
        8'h06: begin
          exp_q.push_back(pk(0, p != 63, 0, 0, 0, 0, 0, 0, 0));
          if (p != 63) np = p + 6'd1;
        end
        8'h01: begin
          exp_q.push_back(pk(0, 0, 0, 1, 0, 6'd0, 0, 0, 0));
          np = 6'd0;
        end
        8'h05: begin
          exp_q.push_back(pk(0, 0, 0, 1, 0, 6'd63, 0, 0, 0));
          np = 6'd63;
        end
        8'h0D: begin
          nxt = (((int'(p) / LineW) + 1) * LineW) % 64;
          np  = 6'(nxt);
          exp_q.push_back(pk(0, 0, 0, 1, 0, np, 0, 0, 0));
        end
        8'h0C: begin
          for (int i = 0; i < 64; i++) exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 1, 6'(i), Fill));
          exp_q.push_back(pk(0, 0, 0, 0, 1, 0, 0, 0, 0));
          np = 6'd0;
        end
        default: exp_q.push_back(26'd0);
      endcase
    end
    key_code  = k;
    key_valid = 1'b1;
    @(posedge CLK); #1;
    key_valid = 1'b0;
    key_code  = 8'($urandom);
    foreach (exp_q[i]) begin
      tests++;
      assert ($countones({increase, decrease, parallel, clear}) <= 1) else begin
        fails++;
        $error("FAIL one_pulse observed=%b expected=at most one",
               {increase, decrease, parallel, clear});
      end
      chk($sformatf("key%02h_cyc%0d", k, i), obs(), exp_q[i]);
      @(posedge CLK); #1;
    end
    chk("ready_after", {25'd0, key_ready}, 26'd1);
    model_pos = np;
  endtask

  logic [7:0] kk;

  initial begin
    CLR_N     = 1'b0;
    key_valid = 1'b0;
    key_code  = 8'h00;
    #12;
    chk("reset_state", obs(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    CLR_N = 1'b1;
    @(posedge CLK); #1;

    set_pos(6'd5);  run_key(8'h41);
    set_pos(6'd63); run_key(8'h5A); run_key(8'h06);
    set_pos(6'd10); run_key(8'h08);
    set_pos(6'd0);  run_key(8'h08);
    set_pos(6'd17); run_key(8'h0D);
    set_pos(6'd50); run_key(8'h0D);
    run_key(8'h05); run_key(8'h01);
    set_pos(6'd33); run_key(8'h0C);

    // Reset in the middle of a sweep: nothing more must come out, in particular no clear.
    set_pos(6'd20);
    key_code  = 8'h0C;
    key_valid = 1'b1;
    @(posedge CLK); #1;
    key_valid = 1'b0;
    repeat (30) @(posedge CLK);
    #1;
    chk("sweep_at_30", obs(), pk(0, 0, 0, 0, 0, 0, 1, 6'd30, Fill));
    CLR_N = 1'b0;
    #1;
    chk("mid_sweep_reset", obs(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    CLR_N = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      tests++;
      assert (!clear && !wr_en) else begin
        fails++;
        $error("FAIL post_reset_quiet observed=%b%b expected=00", clear, wr_en);
      end
    end
    chk("post_reset_pos", {20'd0, q_in}, {20'd0, 6'd20});

    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: kk = 8'($urandom_range(8'h20, 8'h7E));
        3:       kk = 8'h08;
        4:       kk = 8'h02;
        5:       kk = 8'h06;
        6:       kk = ($urandom_range(0, 1) != 0) ? 8'h01 : 8'h05;
        7:       kk = 8'h0D;
        8:       kk = ($urandom_range(0, 15) == 0) ? 8'h0C : 8'h0D;
        default: kk = ($urandom_range(0, 1) != 0) ? 8'h7F : 8'($urandom_range(8'h80, 8'hFF));
      endcase
      run_key(kk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
